// File: rtl/fpu_ftoi.sv
// fpu_ftoi: multi-cycle 16-bit float to 16-bit signed integer converter.
// Ports: clk, rst_n (sync, active-low), start/op in; result, done, busy, ovf, inexact out.
//
// Float layout: sign [15], exponent [14:7], mantissa [6:0] with implied 1.
// Conversion truncates toward zero. Results saturate at 0x7FFF / 0x8000.
// NaN gives 0x0000 with ovf set.
//
// Handshake:
//   start  - request pulse, only sampled while idle; op captured on that edge
//   done   - one-cycle pulse when result/ovf/inexact are updated
//   busy   - high from the accepting edge until the finishing edge
//   result - held between done pulses, as are ovf and inexact

module fpu_ftoi #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] op,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        ovf,
    output logic        inexact
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        SHIFT    = 2'd2,
        FINISH   = 2'd3
    } state_t;

    localparam logic signed [8:0] BIAS_S = 9'(BIAS);

    state_t state_q, state_d;

    // captured operand fields
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [6:0]  mant_q, mant_d;

    // working datapath
    logic [15:0] mag_q, mag_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        sticky_q, sticky_d;
    logic        ovf_w_q, ovf_w_d;
    logic        preset_v_q, preset_v_d;
    logic [15:0] preset_q, preset_d;

    // architectural outputs
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        inexact_q, inexact_d;

    // classification of the captured operand
    logic signed [8:0] e_val;
    logic [3:0]        e_lo;
    logic              is_zero;
    logic              is_max;
    logic              is_small;
    logic              is_big;
    logic              is_norm;
    logic              mant_nz;
    logic [15:0]       sat_val;

    always_comb begin
        e_val    = $signed({1'b0, exp_q}) - BIAS_S;
        e_lo     = e_val[3:0];
        mant_nz  = (mant_q != 7'd0);
        is_zero  = (exp_q == 8'd0);
        is_max   = (exp_q == 8'hFF);
        // exp=0 also yields a negative E, so it is excluded here
        is_small = !is_zero && e_val[8];
        is_big   = !is_max && !e_val[8] && (e_val > 9'sd14);
        is_norm  = !is_zero && !is_max && !is_small && !is_big;
        sat_val  = sign_q ? 16'h8000 : 16'h7FFF;
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        sticky_d   = sticky_q;
        ovf_w_d    = ovf_w_q;
        preset_v_d = preset_v_q;
        preset_d   = preset_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        inexact_d  = inexact_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = op[15];
                    exp_d   = op[14:7];
                    mant_d  = op[6:0];
                    busy_d  = 1'b1;
                    state_d = CLASSIFY;
                end
            end

            CLASSIFY: begin
                mag_d      = 16'd0;
                cnt_d      = 4'd0;
                left_d     = 1'b0;
                sticky_d   = 1'b0;
                ovf_w_d    = 1'b0;
                preset_v_d = 1'b0;
                preset_d   = 16'd0;
                state_d    = FINISH;
                unique case (1'b1)
                    is_zero: begin
                        sticky_d = mant_nz;
                    end
                    is_max: begin
                        ovf_w_d    = 1'b1;
                        preset_v_d = 1'b1;
                        preset_d   = mant_nz ? 16'h0000 : sat_val;
                    end
                    is_small: begin
                        sticky_d = 1'b1;
                    end
                    is_big: begin
                        preset_v_d = 1'b1;
                        preset_d   = sat_val;
                        // exactly -32768 is representable
                        ovf_w_d    = !(sign_q && !mant_nz
                                       && (e_val == 9'sd15));
                    end
                    is_norm: begin
                        mag_d = {8'd0, 1'b1, mant_q};
                        if (e_lo > 4'd7) begin
                            left_d = 1'b1;
                            cnt_d  = e_lo - 4'd7;
                        end else begin
                            left_d = 1'b0;
                            cnt_d  = 4'd7 - e_lo;
                        end
                        if (e_lo != 4'd7) begin
                            state_d = SHIFT;
                        end
                    end
                    default: ;
                endcase
            end

            SHIFT: begin
                if (left_q) begin
                    mag_d = {mag_q[14:0], 1'b0};
                end else begin
                    mag_d    = {1'b0, mag_q[15:1]};
                    sticky_d = sticky_q | mag_q[0];
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                if (preset_v_q) begin
                    result_d = preset_q;
                end else if (sign_q) begin
                    result_d = ~mag_q + 16'd1;
                end else begin
                    result_d = mag_q;
                end
                ovf_d     = ovf_w_q;
                inexact_d = sticky_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= 8'd0;
            mant_q     <= 7'd0;
            mag_q      <= 16'd0;
            cnt_q      <= 4'd0;
            left_q     <= 1'b0;
            sticky_q   <= 1'b0;
            ovf_w_q    <= 1'b0;
            preset_v_q <= 1'b0;
            preset_q   <= 16'd0;
            result_q   <= 16'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            inexact_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            sticky_q   <= sticky_d;
            ovf_w_q    <= ovf_w_d;
            preset_v_q <= preset_v_d;
            preset_q   <= preset_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            inexact_q  <= inexact_d;
        end
    end

    assign result  = result_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign ovf     = ovf_q;
    assign inexact = inexact_q;

endmodule

// File: tb/tb_fpu_ftoi.sv
// tb_fpu_ftoi: directed self-checking bench for fpu_ftoi.
// Hand-computed vectors cover normal, special, saturating and reset cases.

module tb_fpu_ftoi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op = 16'd0;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        ovf;
    logic        inexact;

    int checks = 0;
    int failures = 0;

    fpu_ftoi dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .ovf     (ovf),
        .inexact (inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Issue one conversion and check latency, busy window and outputs.
    task automatic conv(input string tag, input logic [15:0] v,
                        input logic [15:0] er, input logic eo,
                        input logic ei, input int elat);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1;
        op    = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 16'h5A5A;
        chk({tag, ".busy_acc"}, {31'd0, busy}, 32'd1);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done !== 1'b1 && busy === 1'b1) bcnt++;
        end
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".busy_cycles"}, bcnt, elat - 1);
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ".result"}, {16'd0, result}, {16'd0, er});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, ".inexact"}, {31'd0, inexact}, {31'd0, ei});
    endtask

    initial begin
        int lat;
        int dcnt;

        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.result", {16'd0, result}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
        chk("rst.inexact", {31'd0, inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal conversions, issued back-to-back
        conv("p40", 16'h4220, 16'h0028, 1'b0, 1'b0, 4);
        conv("n40", 16'hC220, 16'hFFD8, 1'b0, 1'b0, 4);
        conv("p1_5", 16'h3FC0, 16'h0001, 1'b0, 1'b1, 9);
        conv("n1_5", 16'hBFC0, 16'hFFFF, 1'b0, 1'b1, 9);
        conv("p1_0", 16'h3F80, 16'h0001, 1'b0, 1'b0, 9);
        conv("p192", 16'h4340, 16'h00C0, 1'b0, 1'b0, 2);

        // small magnitudes and zeros
        conv("p0_5", 16'h3F00, 16'h0000, 1'b0, 1'b1, 2);
        conv("n0_5", 16'hBF00, 16'h0000, 1'b0, 1'b1, 2);
        conv("pzero", 16'h0000, 16'h0000, 1'b0, 1'b0, 2);
        conv("nzero", 16'h8000, 16'h0000, 1'b0, 1'b0, 2);
        conv("denorm", 16'h0001, 16'h0000, 1'b0, 1'b1, 2);

        // range boundaries
        conv("p32768", 16'h4700, 16'h7FFF, 1'b1, 1'b0, 2);
        conv("n32768", 16'hC700, 16'h8000, 1'b0, 1'b0, 2);
        conv("n32768p", 16'hC701, 16'h8000, 1'b1, 1'b0, 2);
        conv("p65536", 16'h4780, 16'h7FFF, 1'b1, 1'b0, 2);
        conv("n32640", 16'hC6FF, 16'h8080, 1'b0, 1'b0, 9);
        conv("p32640", 16'h46FF, 16'h7F80, 1'b0, 1'b0, 9);

        // outputs hold while idle
        repeat (3) @(posedge clk);
        #1;
        chk("hold.result", {16'd0, result}, 32'h7F80);
        chk("hold.done", {31'd0, done}, 32'd0);

        // specials
        conv("pinf", 16'h7F80, 16'h7FFF, 1'b1, 1'b0, 2);
        conv("ninf", 16'hFF80, 16'h8000, 1'b1, 1'b0, 2);
        conv("nan", 16'h7FC0, 16'h0000, 1'b1, 1'b0, 2);

        // give outputs a nonzero state before the reset test
        conv("pre_rst", 16'h3FC0, 16'h0001, 1'b0, 1'b1, 9);

        // reset during the third SHIFT cycle
        @(negedge clk);
        start = 1'b1;
        op    = 16'h3FC0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst.result", {16'd0, result}, 32'd0);
        chk("mrst.done", {31'd0, done}, 32'd0);
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        chk("mrst.ovf", {31'd0, ovf}, 32'd0);
        chk("mrst.inexact", {31'd0, inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        chk("mrst.no_done", dcnt, 0);
        chk("mrst.result_held", {16'd0, result}, 32'd0);
        conv("post_rst", 16'h4220, 16'h0028, 1'b0, 1'b0, 4);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1;
        op    = 16'h4220;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 16'h5A5A;
        @(negedge clk);
        start = 1'b1;
        op    = 16'h4700;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 16'h0000;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_start.latency", lat, 4);
        chk("busy_start.result", {16'd0, result}, 32'h0028);
        chk("busy_start.ovf", {31'd0, ovf}, 32'd0);
        dcnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        chk("busy_start.no_extra", dcnt, 0);
        chk("busy_start.held", {16'd0, result}, 32'h0028);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
